// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// frame data width and the baud-divisor helper used at instantiation.
package uart_pkg;

    localparam int DATA_BITS = 8;

    // Reference clock and line rate for the default board build.
    localparam int CLK_HZ    = 1_000_000;
    localparam int BAUD      = 9600;
    localparam int BAUD_DIV  = CLK_HZ / BAUD;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        RECOVER = 3'd5
    } rx_state_t;

    // Clock cycles per bit for a given reference clock and baud rate.
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous input pin.
// Depth and reset value are parameters so other async pins can reuse it.
module sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the flop chain; oldest stage drives q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Samples the synchronized line at mid-bit and emits one byte per frame.
//
// Output protocol: received and recv_error are single-cycle strobes and are
// never high together. On received, rx_byte already holds the new byte and
// keeps it until the next good frame. No back-pressure: the consumer must
// take the byte within one frame time.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       recv_error
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam int             BW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0]  HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 received_q, received_d;
    logic                 recv_error_q, recv_error_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_err_q, par_err_d;
`endif

    sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    // State, counters, shift register and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            rx_byte_q    <= '0;
            received_q   <= 1'b0;
            recv_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            rx_byte_q    <= rx_byte_d;
            received_q   <= received_d;
            recv_error_q <= recv_error_d;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    // Next-state logic: mid-bit sampling, shifting and frame checks.
    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        rx_byte_d    = rx_byte_q;
        received_d   = 1'b0;
        recv_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d    = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    if (rxs) begin
                        // Low pulse shorter than half a bit: treat as noise.
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    shreg_d   = {rxs, shreg_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    // Even parity: data bits plus parity bit must XOR to 0.
                    par_err_d = ^{shreg_q, rxs};
                    state_d   = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    if (rxs) begin
                        // Leaving at mid-stop lets an immediate start bit be caught.
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_err_q) begin
                            recv_error_d = 1'b1;
                        end else begin
                            received_d = 1'b1;
                            rx_byte_d  = shreg_q;
                        end
`else
                        received_d = 1'b1;
                        rx_byte_d  = shreg_q;
`endif
                    end else begin
                        recv_error_d = 1'b1;
                        state_d      = RECOVER;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RECOVER: begin
                // Framing error: wait for the line to return high.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign received     = received_q;
    assign recv_error   = recv_error_q;
    assign rx_byte      = rx_byte_q;
    assign is_receiving = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLKS_PER_BIT=8. Define UART_RX_PARITY_EN for the 8E1 build.
module tb_uart_rx;

    localparam int CPB  = 8;
    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Strobe latency from the rx falling edge: (FRAME_BITS - 0.5) bits + sync + 1.
    localparam int LAT = FRAME_BITS * CPB - CPB / 2 + SYNC + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_receiving;
    logic       recv_error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] last_good;
    logic [7:0] exp_q[$];

    // Monitor storage
    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    int         err_cyc_q[$];
    logic       ir_after_q[$];
    int         both_cnt;
    int         ir_run;
    int         ir_max;
    logic       prev_recv;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .received     (received),
        .rx_byte      (rx_byte),
        .is_receiving (is_receiving),
        .recv_error   (recv_error)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes and is_receiving behaviour away from the active edge.
    always @(negedge clk) begin
        if (received) begin
            got_q.push_back(rx_byte);
            got_cyc_q.push_back(cyc);
        end
        if (recv_error) err_cyc_q.push_back(cyc);
        if (received && recv_error) both_cnt = both_cnt + 1;
        if (prev_recv) ir_after_q.push_back(is_receiving);
        prev_recv = received;
        if (is_receiving) begin
            ir_run = ir_run + 1;
            if (ir_run > ir_max) ir_max = ir_run;
        end else begin
            ir_run = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        got_q.delete();
        got_cyc_q.delete();
        err_cyc_q.delete();
        ir_after_q.delete();
        both_cnt  = 0;
        ir_run    = 0;
        ir_max    = 0;
        prev_recv = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        send_bit(stop_b);
    endtask

    task automatic test_reset();
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (received !== 1'b0) begin bad++; $display("FAIL reset_received: got %b want 0", received); end
        total++; if (rx_byte !== 8'h00) begin bad++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
        total++; if (is_receiving !== 1'b0) begin bad++; $display("FAIL reset_is_receiving: got %b want 0", is_receiving); end
        total++; if (recv_error !== 1'b0) begin bad++; $display("FAIL reset_recv_error: got %b want 0", recv_error); end
        rst_n = 1'b1;
        last_good = 8'h00;
        idle(4);
    endtask

    task automatic test_single();
        int t0;
        int lat;
        clear_mon();
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(2 * CPB);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            total++; if (got_q[0] !== 8'hA5) begin bad++; $display("FAIL single_byte: got %h want a5", got_q[0]); end
            lat = got_cyc_q[0] - t0;
            total++; if (lat < LAT - 1 || lat > LAT + 1) begin bad++; $display("FAIL single_latency: got %0d want %0d+-1", lat, LAT); end
        end
        if (ir_after_q.size() >= 1) begin
            total++; if (ir_after_q[0] !== 1'b0) begin bad++; $display("FAIL single_is_receiving_after: got %b want 0", ir_after_q[0]); end
        end
        total++; if (err_cyc_q.size() !== 0) begin bad++; $display("FAIL single_no_error: got %0d want 0", err_cyc_q.size()); end
        last_good = 8'hA5;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
        idle(2 * CPB);
        total++; if (got_q.size() !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            total++; if (got_q[i] !== 8'(i + 1)) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], 8'(i + 1)); end
        end
        for (int i = 1; i < got_cyc_q.size() && i < 4; i++) begin
            total++;
            if (got_cyc_q[i] - got_cyc_q[i-1] !== FRAME_BITS * CPB) begin
                bad++; $display("FAIL b2b_spacing%0d: got %0d want %0d", i, got_cyc_q[i] - got_cyc_q[i-1], FRAME_BITS * CPB);
            end
        end
        total++; if (err_cyc_q.size() !== 0) begin bad++; $display("FAIL b2b_no_error: got %0d want 0", err_cyc_q.size()); end
        last_good = 8'h04;
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * CPB);
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL glitch_received: got %0d want 0", got_q.size()); end
        total++; if (err_cyc_q.size() !== 0) begin bad++; $display("FAIL glitch_error: got %0d want 0", err_cyc_q.size()); end
        total++; if (ir_max < 1 || ir_max > 7) begin bad++; $display("FAIL glitch_is_receiving_run: got %0d want 1..7", ir_max); end
        total++; if (is_receiving !== 1'b0) begin bad++; $display("FAIL glitch_is_receiving_end: got %b want 0", is_receiving); end
    endtask

    task automatic test_framing_error();
        clear_mon();
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(20);
        total++; if (err_cyc_q.size() !== 1) begin bad++; $display("FAIL frame_err_count: got %0d want 1", err_cyc_q.size()); end
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL frame_err_received: got %0d want 0", got_q.size()); end
        total++; if (rx_byte !== last_good) begin bad++; $display("FAIL frame_err_hold: got %h want %h", rx_byte, last_good); end
        clear_mon();
        send_frame(8'h55, 1'b1, 1'b0);
        idle(2 * CPB);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL frame_err_next_count: got %0d want 1", got_q.size()); end
        total++; if (rx_byte !== 8'h55) begin bad++; $display("FAIL frame_err_next_byte: got %h want 55", rx_byte); end
        last_good = 8'h55;
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (received !== 1'b0) begin bad++; $display("FAIL midrst_received: got %b want 0", received); end
        total++; if (rx_byte !== 8'h00) begin bad++; $display("FAIL midrst_rx_byte: got %h want 00", rx_byte); end
        total++; if (is_receiving !== 1'b0) begin bad++; $display("FAIL midrst_is_receiving: got %b want 0", is_receiving); end
        total++; if (recv_error !== 1'b0) begin bad++; $display("FAIL midrst_recv_error: got %b want 0", recv_error); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_good = 8'h00;
        idle(5 * CPB);
        total++; if (got_q.size() !== 0 || err_cyc_q.size() !== 0) begin
            bad++; $display("FAIL midrst_tail: got rcv=%0d err=%0d want 0 0", got_q.size(), err_cyc_q.size());
        end
        clear_mon();
        send_frame(8'h12, 1'b1, 1'b0);
        idle(2 * CPB);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL midrst_next_count: got %0d want 1", got_q.size()); end
        total++; if (rx_byte !== 8'h12) begin bad++; $display("FAIL midrst_next_byte: got %h want 12", rx_byte); end
        last_good = 8'h12;
    endtask

    task automatic test_random();
        int         n_err_exp;
        logic [7:0] d;
        logic       bad_stop;
        logic       pf;
        int         gap;
        clear_mon();
        exp_q.delete();
        n_err_exp = 0;
        for (int k = 0; k < 16; k++) begin
            d        = 8'($urandom_range(0, 255));
            bad_stop = ($urandom_range(0, 4) == 0);
            pf       = 1'b0;
`ifdef UART_RX_PARITY_EN
            pf       = ($urandom_range(0, 3) == 0);
`endif
            send_frame(d, !bad_stop, pf);
            if (bad_stop || pf) begin
                n_err_exp++;
            end else begin
                exp_q.push_back(d);
                last_good = d;
            end
            gap = bad_stop ? $urandom_range(CPB, 3 * CPB) : $urandom_range(0, 2 * CPB);
            idle(gap);
        end
        idle(2 * CPB);
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (err_cyc_q.size() !== n_err_exp) begin bad++; $display("FAIL rand_errors: got %0d want %0d", err_cyc_q.size(), n_err_exp); end
        total++; if (rx_byte !== last_good) begin bad++; $display("FAIL rand_last_byte: got %h want %h", rx_byte, last_good); end
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL rand_exclusive: got %0d overlapping cycles want 0", both_cnt); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_mon();
        send_frame(8'h03, 1'b1, 1'b0);
        idle(2 * CPB);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL par_good_count: got %0d want 1", got_q.size()); end
        total++; if (rx_byte !== 8'h03) begin bad++; $display("FAIL par_good_byte: got %h want 03", rx_byte); end
        last_good = 8'h03;
        clear_mon();
        send_frame(8'h03, 1'b1, 1'b1);
        idle(2 * CPB);
        total++; if (err_cyc_q.size() !== 1) begin bad++; $display("FAIL par_bad_error: got %0d want 1", err_cyc_q.size()); end
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL par_bad_received: got %0d want 0", got_q.size()); end
        total++; if (rx_byte !== last_good) begin bad++; $display("FAIL par_bad_hold: got %h want %h", rx_byte, last_good); end
    endtask
`endif

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        clear_mon();
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
